// File: rtl/ascon_aead_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_aead_ctrl
// Control and state-update wrapper around an external Ascon permutation.
// Holds the 320-bit state S = {x0..x4}, sequences initialisation, associated
// data absorption, domain separation, message encrypt/decrypt and
// finalisation, and produces the 128-bit tag.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               begin an operation (sampled only in IDLE)
//   decrypt             0 = encrypt, 1 = decrypt (latched at start)
//   ad_none, msg_none   no associated data / no message (latched at start)
//   key, nonce          128-bit K and N (latched at start)
//   din/din_valid/din_last/din_ready   64-bit AD or message block input
//   dout/dout_valid     64-bit ciphertext or plaintext output, one-cycle pulse
//   tag, done           computed tag and its one-cycle valid pulse
//   busy                high from start accept until the tag cycle ends
//   perm_start, perm_rounds, perm_x*_in    request to the permutation
//   perm_x*_out, perm_done                 result from the permutation
// ---------------------------------------------------------------------------
module ascon_aead_ctrl #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic         ad_none,
  input  logic         msg_none,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [63:0]  din,
  input  logic         din_valid,
  input  logic         din_last,
  output logic         din_ready,
  output logic [63:0]  dout,
  output logic         dout_valid,
  output logic [127:0] tag,
  output logic         done,
  output logic         busy,
  output logic         perm_start,
  output logic [3:0]   perm_rounds,
  output logic [63:0]  perm_x0_in,
  output logic [63:0]  perm_x1_in,
  output logic [63:0]  perm_x2_in,
  output logic [63:0]  perm_x3_in,
  output logic [63:0]  perm_x4_in,
  input  logic [63:0]  perm_x0_out,
  input  logic [63:0]  perm_x1_out,
  input  logic [63:0]  perm_x2_out,
  input  logic [63:0]  perm_x3_out,
  input  logic [63:0]  perm_x4_out,
  input  logic         perm_done
);

  localparam logic [63:0] ASCON_IV = 64'h80400C0600000000;
  localparam logic [3:0]  PA_R4    = 4'(PA_ROUNDS);
  localparam logic [3:0]  PB_R4    = 4'(PB_ROUNDS);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_AD_WAIT  = 4'd2,
    ST_AD_PERM  = 4'd3,
    ST_DOM      = 4'd4,
    ST_MSG_WAIT = 4'd5,
    ST_MSG_PERM = 4'd6,
    ST_FINAL    = 4'd7,
    ST_TAG      = 4'd8
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [63:0]  r_x0, r_x1, r_x2, r_x3, r_x4;
  logic [127:0] r_key;
  logic         r_decrypt;
  logic         r_ad_none;
  logic         r_msg_none;
  logic         r_ad_last;
  logic [63:0]  r_dout;
  logic         r_dout_valid;
  logic [127:0] r_tag;
  logic         r_done;
  logic         r_busy;
  logic         r_perm_start;
  logic [3:0]   r_perm_rounds;

  logic         w_din_ready;
  logic         w_hs;
  logic         w_perm_state;
  logic         w_perm_ack;
  logic         w_enter_perm;
  logic [3:0]   w_next_rounds;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_INIT; else w_next = ST_IDLE;
      ST_INIT:     if (w_perm_ack) w_next = r_ad_none ? ST_DOM : ST_AD_WAIT;
                   else w_next = ST_INIT;
      ST_AD_WAIT:  if (w_hs) w_next = ST_AD_PERM; else w_next = ST_AD_WAIT;
      ST_AD_PERM:  if (w_perm_ack) w_next = r_ad_last ? ST_DOM : ST_AD_WAIT;
                   else w_next = ST_AD_PERM;
      ST_DOM:      w_next = r_msg_none ? ST_FINAL : ST_MSG_WAIT;
      ST_MSG_WAIT: if (w_hs) w_next = din_last ? ST_FINAL : ST_MSG_PERM;
                   else w_next = ST_MSG_WAIT;
      ST_MSG_PERM: if (w_perm_ack) w_next = ST_MSG_WAIT; else w_next = ST_MSG_PERM;
      ST_FINAL:    if (w_perm_ack) w_next = ST_TAG; else w_next = ST_FINAL;
      ST_TAG:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Moore decode of the current state: input handshake and permutation acceptance.
  // A perm_done in the same cycle as our own perm_start pulse cannot belong to
  // this request, so it is not accepted.
  always_comb begin
    w_din_ready  = 1'b0;
    w_perm_state = 1'b0;
    case (r_state)
      ST_AD_WAIT, ST_MSG_WAIT:                 w_din_ready  = 1'b1;
      ST_INIT, ST_AD_PERM, ST_MSG_PERM, ST_FINAL: w_perm_state = 1'b1;
      default: begin
        w_din_ready  = 1'b0;
        w_perm_state = 1'b0;
      end
    endcase
    w_hs       = din_valid & w_din_ready;
    w_perm_ack = perm_done & w_perm_state & ~r_perm_start;
  end

  // Permutation launch: pulse once when a permutation state is entered.
  always_comb begin
    w_enter_perm  = 1'b0;
    w_next_rounds = PB_R4;
    if (w_next != r_state) begin
      case (w_next)
        ST_INIT, ST_FINAL: begin
          w_enter_perm  = 1'b1;
          w_next_rounds = PA_R4;
        end
        ST_AD_PERM, ST_MSG_PERM: begin
          w_enter_perm  = 1'b1;
          w_next_rounds = PB_R4;
        end
        default: begin
          w_enter_perm  = 1'b0;
          w_next_rounds = PB_R4;
        end
      endcase
    end else begin
      w_enter_perm  = 1'b0;
      w_next_rounds = PB_R4;
    end
  end

  // Datapath: state S, latched operation parameters and registered outputs.
  // Key injection for FINAL is applied on the edge that enters FINAL so the
  // state seen with perm_start already carries it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0          <= 64'd0;
      r_x1          <= 64'd0;
      r_x2          <= 64'd0;
      r_x3          <= 64'd0;
      r_x4          <= 64'd0;
      r_key         <= 128'd0;
      r_decrypt     <= 1'b0;
      r_ad_none     <= 1'b0;
      r_msg_none    <= 1'b0;
      r_ad_last     <= 1'b0;
      r_dout        <= 64'd0;
      r_dout_valid  <= 1'b0;
      r_tag         <= 128'd0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_perm_start  <= 1'b0;
      r_perm_rounds <= 4'd0;
    end else begin
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_perm_start <= w_enter_perm;
      if (w_enter_perm) begin
        r_perm_rounds <= w_next_rounds;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x0       <= ASCON_IV;
            r_x1       <= key[127:64];
            r_x2       <= key[63:0];
            r_x3       <= nonce[127:64];
            r_x4       <= nonce[63:0];
            r_key      <= key;
            r_decrypt  <= decrypt;
            r_ad_none  <= ad_none;
            r_msg_none <= msg_none;
            r_busy     <= 1'b1;
          end
        end
        ST_INIT: begin
          if (w_perm_ack) begin
            r_x0 <= perm_x0_out;
            r_x1 <= perm_x1_out;
            r_x2 <= perm_x2_out;
            r_x3 <= perm_x3_out ^ r_key[127:64];
            r_x4 <= perm_x4_out ^ r_key[63:0];
          end
        end
        ST_AD_PERM, ST_MSG_PERM: begin
          if (w_perm_ack) begin
            r_x0 <= perm_x0_out;
            r_x1 <= perm_x1_out;
            r_x2 <= perm_x2_out;
            r_x3 <= perm_x3_out;
            r_x4 <= perm_x4_out;
          end
        end
        ST_AD_WAIT: begin
          if (w_hs) begin
            r_x0      <= r_x0 ^ din;
            r_ad_last <= din_last;
          end
        end
        ST_DOM: begin
          r_x4 <= r_x4 ^ 64'h1;
          if (r_msg_none) begin
            r_x1 <= r_x1 ^ r_key[127:64];
            r_x2 <= r_x2 ^ r_key[63:0];
          end
        end
        ST_MSG_WAIT: begin
          if (w_hs) begin
            r_dout       <= r_x0 ^ din;
            r_dout_valid <= 1'b1;
            // Decrypt keeps the ciphertext as the new rate word.
            r_x0         <= r_decrypt ? din : (r_x0 ^ din);
            if (din_last) begin
              r_x1 <= r_x1 ^ r_key[127:64];
              r_x2 <= r_x2 ^ r_key[63:0];
            end
          end
        end
        ST_FINAL: begin
          if (w_perm_ack) begin
            r_x0   <= perm_x0_out;
            r_x1   <= perm_x1_out;
            r_x2   <= perm_x2_out;
            r_x3   <= perm_x3_out;
            r_x4   <= perm_x4_out;
            r_tag  <= {perm_x3_out ^ r_key[127:64], perm_x4_out ^ r_key[63:0]};
            r_done <= 1'b1;
          end
        end
        ST_TAG: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready   = w_din_ready;
  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign tag         = r_tag;
  assign done        = r_done;
  assign busy        = r_busy;
  assign perm_start  = r_perm_start;
  assign perm_rounds = r_perm_rounds;
  assign perm_x0_in  = r_x0;
  assign perm_x1_in  = r_x1;
  assign perm_x2_in  = r_x2;
  assign perm_x3_in  = r_x3;
  assign perm_x4_in  = r_x4;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascon_aead_ctrl
// Bench for ascon_aead_ctrl with an identity permutation stub (perm_done two
// cycles after perm_start). Table-driven operations plus reset and
// start-while-busy sequences.
// ---------------------------------------------------------------------------
module tb_ascon_aead_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic         ad_none = 1'b0;
  logic         msg_none = 1'b0;
  logic [127:0] key = 128'd0;
  logic [127:0] nonce = 128'd0;
  logic [63:0]  din = 64'd0;
  logic         din_valid = 1'b0;
  logic         din_last = 1'b0;
  logic         din_ready;
  logic [63:0]  dout;
  logic         dout_valid;
  logic [127:0] tag;
  logic         done;
  logic         busy;
  logic         perm_start;
  logic [3:0]   perm_rounds;
  logic [63:0]  perm_x0_in, perm_x1_in, perm_x2_in, perm_x3_in, perm_x4_in;
  logic [63:0]  perm_x0_out, perm_x1_out, perm_x2_out, perm_x3_out, perm_x4_out;
  logic         perm_done;

  always #5 clk = ~clk;

  ascon_aead_ctrl #(.PA_ROUNDS(12), .PB_ROUNDS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .ad_none(ad_none), .msg_none(msg_none), .key(key), .nonce(nonce),
    .din(din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .tag(tag), .done(done), .busy(busy),
    .perm_start(perm_start), .perm_rounds(perm_rounds),
    .perm_x0_in(perm_x0_in), .perm_x1_in(perm_x1_in), .perm_x2_in(perm_x2_in),
    .perm_x3_in(perm_x3_in), .perm_x4_in(perm_x4_in),
    .perm_x0_out(perm_x0_out), .perm_x1_out(perm_x1_out), .perm_x2_out(perm_x2_out),
    .perm_x3_out(perm_x3_out), .perm_x4_out(perm_x4_out),
    .perm_done(perm_done)
  );

  // Identity permutation stub; not reset, so a request in flight survives rst.
  logic p1 = 1'b0;
  logic p2 = 1'b0;
  always @(posedge clk) begin
    p1 <= perm_start;
    p2 <= p1;
  end
  assign perm_done   = p2;
  assign perm_x0_out = perm_x0_in;
  assign perm_x1_out = perm_x1_in;
  assign perm_x2_out = perm_x2_in;
  assign perm_x3_out = perm_x3_in;
  assign perm_x4_out = perm_x4_in;

  // Event monitor, sampled mid-cycle.
  int           perm_cnt  = 0;
  int           dout_cnt  = 0;
  int           done_cnt  = 0;
  int           ready_cnt = 0;
  logic [3:0]   rnd_log  [256];
  logic [63:0]  dout_log [256];
  logic [127:0] tag_at_done = 128'd0;
  always @(negedge clk) begin
    if (perm_start) begin
      rnd_log[perm_cnt % 256] <= perm_rounds;
      perm_cnt <= perm_cnt + 1;
    end
    if (dout_valid) begin
      dout_log[dout_cnt % 256] <= dout;
      dout_cnt <= dout_cnt + 1;
    end
    if (done) begin
      tag_at_done <= tag;
      done_cnt <= done_cnt + 1;
    end
    if (din_ready) begin
      ready_cnt <= ready_cnt + 1;
    end
  end

  typedef struct {
    bit                dec;
    bit                adn;
    bit                msgn;
    logic [127:0]      k;
    logic [127:0]      n;
    int                n_ad;
    logic [1:0][63:0]  ad;
    int                n_msg;
    logic [2:0][63:0]  msg;
    logic [2:0][63:0]  edout;
    logic [127:0]      etag;
    int                nperm;
    logic [5:0][3:0]   rnds;
  } vec_t;

  vec_t vecs [6];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   busy_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_bad++;
      tick();
    end
  endtask

  task automatic wait_done(input int n0);
    for (int k = 0; k < 100; k++) begin
      if (done_cnt != n0) break;
      if (!busy) busy_bad++;
      tick();
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int p0, d0, n0, r0, b0;
    bit ok;
    v  = vecs[idx];
    p0 = perm_cnt; d0 = dout_cnt; n0 = done_cnt; r0 = ready_cnt; b0 = busy_bad;
    decrypt = v.dec; ad_none = v.adn; msg_none = v.msgn; key = v.k; nonce = v.n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < v.n_ad; a++) begin
      wait_ready(ok);
      chk($sformatf("v%0d ad%0d ready", idx, a), ok, 1'b1);
      din = v.ad[a]; din_last = (a == v.n_ad - 1); din_valid = 1'b1;
      tick();
      din_valid = 1'b0; din_last = 1'b0;
    end
    for (int m = 0; m < v.n_msg; m++) begin
      wait_ready(ok);
      chk($sformatf("v%0d msg%0d ready", idx, m), ok, 1'b1);
      din = v.msg[m]; din_last = (m == v.n_msg - 1); din_valid = 1'b1;
      tick();
      din_valid = 1'b0; din_last = 1'b0;
    end
    wait_done(n0);
    tick();
    tick();
    chk($sformatf("v%0d done pulses", idx), done_cnt - n0, 1);
    chk($sformatf("v%0d tag", idx), tag_at_done, v.etag);
    chk($sformatf("v%0d busy held", idx), busy_bad - b0, 0);
    chk($sformatf("v%0d busy after", idx), busy, 1'b0);
    chk($sformatf("v%0d perm count", idx), perm_cnt - p0, v.nperm);
    for (int j = 0; j < v.nperm; j++)
      chk($sformatf("v%0d rounds%0d", idx, j), rnd_log[(p0 + j) % 256], v.rnds[j]);
    chk($sformatf("v%0d dout count", idx), dout_cnt - d0, v.n_msg);
    for (int j = 0; j < v.n_msg; j++)
      chk($sformatf("v%0d dout%0d", idx, j), dout_log[(d0 + j) % 256], v.edout[j]);
    if (v.adn && v.msgn)
      chk($sformatf("v%0d no ready", idx), ready_cnt - r0, 0);
  endtask

  localparam logic [127:0] KA = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NA = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [63:0]  M1 = 64'h0123456789ABCDEF;
  localparam logic [63:0]  M2 = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0]  M3 = 64'h1000000000000001;
  localparam logic [63:0]  C1 = 64'h816349618954CD10;
  localparam logic [63:0]  C2 = 64'h7E9CB69E76AB32EF;
  localparam logic [63:0]  C3 = 64'h6E9CB69E76AB32EE;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, d0, n0, b0, lowcnt, k;
    bit ok;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 128'h0, 128'h0, 0, 128'h0, 1,
                {128'h0, 64'h1111111111111111}, {128'h0, 64'h91511D1711111111},
                128'h1, 2, {16'h0, 4'd12, 4'd12}};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 128'h0, 128'h0, 0, 128'h0, 1,
                {128'h0, 64'h91511D1711111111}, {128'h0, 64'h1111111111111111},
                128'h1, 2, {16'h0, 4'd12, 4'd12}};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 128'h0, 128'h0, 0, 128'h0, 0,
                192'h0, 192'h0, 128'h1, 2, {16'h0, 4'd12, 4'd12}};
    vecs[3] = '{1'b0, 1'b0, 1'b0, KA, NA, 2,
                {64'h0000000000FF0000, 64'h00000000000000FF}, 3,
                {M3, M2, M1}, {C3, C2, C1},
                128'h101112131415161718191A1B1C1D1E1E, 6,
                {4'd12, 4'd6, 4'd6, 4'd6, 4'd6, 4'd12}};
    vecs[4] = '{1'b1, 1'b0, 1'b0, KA, NA, 2,
                {64'h0000000000FF0000, 64'h00000000000000FF}, 3,
                {C3, C2, C1}, {M3, M2, M1},
                128'h101112131415161718191A1B1C1D1E1E, 6,
                {4'd12, 4'd6, 4'd6, 4'd6, 4'd6, 4'd12}};
    vecs[5] = '{1'b0, 1'b0, 1'b1, KA, 128'h0, 1,
                {64'h0, 64'h0000000000001234}, 0, 192'h0, 192'h0,
                128'h1, 3, {12'h0, 4'd12, 4'd6, 4'd12}};

    // Reset state.
    tick();
    tick();
    chk("reset ctrl outs", {dout, dout_valid, done, busy, din_ready, perm_start, perm_rounds}, 128'd0);
    chk("reset tag", tag, 128'd0);
    chk("reset x0x1", {perm_x0_in, perm_x1_in}, 128'd0);
    chk("reset x2x3", {perm_x2_in, perm_x3_in}, 128'd0);
    chk("reset x4", perm_x4_in, 128'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);

    // start pulsed while busy, din_valid held from INIT onward.
    p0 = perm_cnt; d0 = dout_cnt; n0 = done_cnt;
    decrypt = 1'b0; ad_none = 1'b1; msg_none = 1'b0; key = 128'h0; nonce = 128'h0;
    din = 64'h1111111111111111; din_last = 1'b1; din_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lowcnt = 0;
    k = 0;
    while (!din_ready && k < 20) begin
      lowcnt++;
      start = (k == 1);
      tick();
      k++;
    end
    start = 1'b0;
    chk("busy-start ready seen", din_ready, 1'b1);
    chk("busy-start ready low in init", (lowcnt >= 3), 1'b1);
    tick();
    din_valid = 1'b0; din_last = 1'b0;
    wait_done(n0);
    tick();
    tick();
    chk("busy-start done", done_cnt - n0, 1);
    chk("busy-start tag", tag_at_done, 128'h1);
    chk("busy-start dout", dout_log[d0 % 256], 64'h91511D1711111111);
    chk("busy-start dout count", dout_cnt - d0, 1);
    chk("busy-start perm count", perm_cnt - p0, 2);

    // Reset while a MSG_PERM permutation is outstanding.
    decrypt = 1'b0; ad_none = 1'b1; msg_none = 1'b0; key = KA; nonce = NA;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(ok);
    chk("rst seq ready", ok, 1'b1);
    din = M1; din_last = 1'b0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("rst seq perm launched", perm_start, 1'b1);
    tick();
    rst = 1'b1;
    #2;
    chk("rst mid ctrl outs", {dout, dout_valid, done, busy, din_ready, perm_start, perm_rounds}, 128'd0);
    chk("rst mid tag", tag, 128'd0);
    chk("rst mid state", {perm_x0_in ^ perm_x1_in ^ perm_x2_in, perm_x3_in | perm_x4_in}, 128'd0);
    rst = 1'b0;
    p0 = perm_cnt; b0 = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (busy || din_ready) b0++;
    end
    chk("late perm_done ignored", b0, 0);
    chk("late perm_done no launch", perm_cnt - p0, 0);
    run_vec(0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
